// File: rtl/alu_stream.sv
// Handshaked ALU with NZCV flags; define ALU_STREAM_MUL_EN to build the
// iterative shift-add multiplier for opcode 111 (otherwise 111 is PASS a).
module alu_stream #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   localparam int SW = $clog2(WIDTH);
   localparam int M  = WIDTH - 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             accept;

   logic [SW-1:0]    shamt;
   logic [WIDTH:0]   sum_x, dif_x, shl_x, shr_x;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [3:0]       alu_flags;

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_HOLD);
   assign result    = result_q;
   assign flags     = flags_q;

   // Extra top/bottom bit on each path captures carry, borrow or the last bit shifted out.
   assign shamt = b[SW-1:0];
   assign sum_x = {1'b0, a} + {1'b0, b};
   assign dif_x = {1'b0, a} - {1'b0, b};
   assign shl_x = {1'b0, a} << shamt;
   assign shr_x = {a, 1'b0} >> shamt;

   always_comb begin
      alu_res = a;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum_x[M:0];
            alu_c   = sum_x[WIDTH];
            alu_v   = (a[M] == b[M]) && (alu_res[M] != a[M]);
         end
         OP_SUB: begin
            alu_res = dif_x[M:0];
            alu_c   = dif_x[WIDTH];
            alu_v   = (a[M] != b[M]) && (alu_res[M] != a[M]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin
            alu_res = shl_x[M:0];
            alu_c   = shl_x[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_x[WIDTH:1];
            alu_c   = shr_x[0];
         end
         default: alu_res = a;
      endcase
      alu_flags = {alu_res[M], (alu_res == '0), alu_c, alu_v};
   end

`ifdef ALU_STREAM_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SW-1:0]    cnt_q, cnt_d;

   // One partial product per BUSY cycle; acc_d holds the final product on the last step.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (accept && op == OP_MUL) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (state_q == S_BUSY) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      if (accept) begin
`ifdef ALU_STREAM_MUL_EN
         if (op == OP_MUL) begin
            state_d = S_BUSY;
         end else begin
            state_d  = S_HOLD;
            result_d = alu_res;
            flags_d  = alu_flags;
         end
`else
         state_d  = S_HOLD;
         result_d = alu_res;
         flags_d  = alu_flags;
`endif
      end else begin
         case (state_q)
            S_HOLD: if (out_ready) state_d = S_IDLE;
`ifdef ALU_STREAM_MUL_EN
            S_BUSY: begin
               if (cnt_q == SW'(WIDTH - 1)) begin
                  state_d  = S_HOLD;
                  result_d = acc_d;
                  flags_d  = {acc_d[M], (acc_d == '0), 2'b00};
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_stream.sv
// Scoreboard bench for alu_stream (WIDTH=16): directed vectors, back-to-back,
// output stall, multiply/PASS latency and reset during an operation.
module tb_alu_stream;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic [3:0]   flags;

   typedef struct packed {
      logic [W-1:0] r;
      logic [3:0]   f;
   } exp_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [3:0]   f;
   } vec_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   alu_stream #(.WIDTH(W)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented-and-taken result must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (nreset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got %h, expected no output", result);
         end else begin
            e = sb.pop_front();
            check("result", result, e.r);
            check("flags", flags, e.f);
         end
      end
   end

   // Entered at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic [3:0] ef);
      int t;
      exp_t e;
      op = o; a = x; b = y; in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready=%0b, expected 1 within 50 cycles", in_ready);
      end else begin
         e.r = er;
         e.f = ef;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   vec_t vt[16];
   int   c0, lat;
   bit   busy_ok, stale;

   initial begin
      vt[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
      vt[1]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
      vt[2]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
      vt[3]  = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 4'b0010};
      vt[4]  = '{3'd6, 16'h0003, 16'h0011, 16'h0001, 4'b0010};
      vt[5]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
      vt[6]  = '{3'd3, 16'h8000, 16'h0001, 16'h8001, 4'b1000};
      vt[7]  = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 4'b0100};
      vt[8]  = '{3'd5, 16'h8000, 16'h0010, 16'h8000, 4'b1000};
      vt[9]  = '{3'd6, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
      vt[10] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
      vt[11] = '{3'd5, 16'h0001, 16'h000F, 16'h8000, 4'b1000};
      vt[12] = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 4'b0100};
      vt[13] = '{3'd6, 16'h0005, 16'h0001, 16'h0002, 4'b0010};
      vt[14] = '{3'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b1011};
      vt[15] = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 4'b0111};

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 16'h0000);
      check("rst_flags", flags, 4'h0);
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      check("rel_in_ready", in_ready, 1'b1);

      // Directed single-cycle vectors, issued back-to-back
      for (int i = 0; i < 16; i++) send(vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].f);
      idle(2);

      // Four ADDs must take exactly four cycles with out_ready held high
      c0 = cyc;
      send(3'd0, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
      send(3'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
      send(3'd0, 16'h0010, 16'h0020, 16'h0030, 4'b0000);
      send(3'd0, 16'hFFFE, 16'h0001, 16'hFFFF, 4'b1000);
      check("b2b_cycles", cyc - c0, 4);
      idle(2);

      // Output stall: result held, no accept
      out_ready = 1'b0;
      send(3'd0, 16'h0005, 16'h0006, 16'h000B, 4'b0000);
      in_valid = 1'b1;
      op = 3'd4; a = 16'hAAAA; b = 16'h5555;
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1'b1);
         check("stall_result", result, 16'h000B);
         check("stall_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      idle(2);

      // Multiply (or PASS) latency
`ifdef ALU_STREAM_MUL_EN
      send(3'd7, 16'h0123, 16'h0010, 16'h1230, 4'b0000);
`else
      send(3'd7, 16'h0123, 16'h0010, 16'h0123, 4'b0000);
`endif
      in_valid = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
`ifdef ALU_STREAM_MUL_EN
      check("mul_latency", lat, W + 1);
      check("mul_busy_no_ready", busy_ok, 1'b1);
      idle(2);
      send(3'd7, 16'h00FF, 16'h0101, 16'hFFFF, 4'b1000);
`else
      check("pass_latency", lat, 1);
      idle(2);
      send(3'd7, 16'h00FF, 16'h0101, 16'h00FF, 4'b0000);
`endif
      idle(W + 4);

      // Reset in the middle of an operation (BUSY cycle 5, or HOLD without multiplier)
      out_ready = 1'b0;
      send(3'd7, 16'h0123, 16'h0010, 16'h0000, 4'b0000);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      nreset = 1'b0;
      #1;
      sb.delete();
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_result", result, 16'h0000);
      check("midrst_flags", flags, 4'h0);
      @(negedge clk);
      nreset = 1'b1;
      #1;
      check("midrst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      stale = 1'b0;
      repeat (W + 6) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("no_stale_result", stale, 1'b0);

      @(posedge clk);
      #1;
      send(3'd0, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
      idle(3);
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

endmodule
